// File: rtl/iq_window_accumulator.sv
// -----------------------------------------------------------------------------
// iq_window_accumulator
//
// Integrates demodulated signed I/Q samples over a programmable window and
// hands the two sums to the ML inference wrapper with a one-cycle trigger.
// A new window is issued only while the inference core reports idle.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous, active-low reset
//   arm              in   request one accumulation window (level)
//   window_len       in   samples per window, latched when arm is accepted
//   sample_valid     in   sample_i/sample_q valid this cycle
//   sample_i         in   signed in-phase sample
//   sample_q         in   signed quadrature sample
//   ml_idle          in   inference core idle; results issued only while high
//   accumulated_data out  {acc_i, acc_q}, I in the upper half
//   start_trigger    out  one-cycle pulse when accumulated_data is updated
//   saturated        out  a clamp happened in the issued window
//   busy             out  high while accumulating or waiting to issue
// -----------------------------------------------------------------------------
module iq_window_accumulator #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 32,
    parameter int LEN_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic [LEN_W-1:0]           window_len,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic signed [SAMPLE_W-1:0] sample_q,
    input  logic                       ml_idle,
    output logic [2*ACC_W-1:0]         accumulated_data,
    output logic                       start_trigger,
    output logic                       saturated,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The sum is formed one bit wider than the accumulator; a disagreement of
    // the top two bits means the true result left the ACC_W range.
    function automatic logic sat_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
        if (sat_ovf(s))
            return s[ACC_W] ? $signed({1'b1, {(ACC_W-1){1'b0}}})
                            : $signed({1'b0, {(ACC_W-1){1'b1}}});
        else
            return $signed(s[ACC_W-1:0]);
    endfunction

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic [LEN_W-1:0]          cnt_inc;
    logic signed [ACC_W-1:0]   acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0]   acc_q_q, acc_q_d;
    logic                      sat_q, sat_d;
    logic [2*ACC_W-1:0]        data_q, data_d;
    logic                      sat_out_q, sat_out_d;
    logic                      trig_q, trig_d;
    logic                      busy_q, busy_d;
    logic signed [ACC_W:0]     sum_i, sum_q;

    assign sum_i   = (ACC_W+1)'(acc_i_q) + (ACC_W+1)'(sample_i);
    assign sum_q   = (ACC_W+1)'(acc_q_q) + (ACC_W+1)'(sample_q);
    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        sat_d     = sat_q;
        data_d    = data_q;
        sat_out_d = sat_out_q;
        trig_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A zero-length request is dropped; a sample arriving with
                // the accepted arm is not part of the window.
                if (arm && (window_len != '0)) begin
                    len_d   = window_len;
                    cnt_d   = '0;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (sample_valid) begin
                    acc_i_d = sat_clamp(sum_i);
                    acc_q_d = sat_clamp(sum_q);
                    sat_d   = sat_q | sat_ovf(sum_i) | sat_ovf(sum_q);
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (ml_idle) begin
                    data_d    = {acc_i_q, acc_q_q};
                    sat_out_d = sat_q;
                    trig_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ACCUM) || (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            sat_q     <= 1'b0;
            data_q    <= '0;
            sat_out_q <= 1'b0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            sat_q     <= sat_d;
            data_q    <= data_d;
            sat_out_q <= sat_out_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
        end
    end

    assign accumulated_data = data_q;
    assign start_trigger    = trig_q;
    assign saturated        = sat_out_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_iq_window_accumulator.sv
module tb_iq_window_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, arm, sample_valid, ml_idle;
    logic [9:0]          window_len;
    logic signed [15:0]  sample_i, sample_q;

    logic [63:0] d32;
    logic        t32, s32, b32;
    logic [35:0] d18;
    logic        t18, s18, b18;

    iq_window_accumulator #(.SAMPLE_W(16), .ACC_W(32), .LEN_W(10)) dut32 (
        .clk(clk), .rst(rst), .arm(arm), .window_len(window_len),
        .sample_valid(sample_valid), .sample_i(sample_i), .sample_q(sample_q),
        .ml_idle(ml_idle), .accumulated_data(d32), .start_trigger(t32),
        .saturated(s32), .busy(b32));

    iq_window_accumulator #(.SAMPLE_W(16), .ACC_W(18), .LEN_W(10)) dut18 (
        .clk(clk), .rst(rst), .arm(arm), .window_len(window_len),
        .sample_valid(sample_valid), .sample_i(sample_i), .sample_q(sample_q),
        .ml_idle(ml_idle), .accumulated_data(d18), .start_trigger(t18),
        .saturated(s18), .busy(b18));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: index 0 is the 32-bit accumulator, index 1 the 18-bit one.
    int     W [2] = '{32, 18};
    longint m_acc_i [2], m_acc_q [2];
    bit     m_sat   [2];
    longint e_i     [2], e_q [2];
    bit     e_sat   [2];
    bit     collecting, waiting, e_trig, e_busy;
    int     m_len, m_got;

    function automatic longint add_clamp(longint a, longint b, int w, output bit ovf);
        longint hi, lo, v;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -hi - 1;
        v   = a + b;
        ovf = 1'b0;
        if (v > hi) begin v = hi; ovf = 1'b1; end
        else if (v < lo) begin v = lo; ovf = 1'b1; end
        return v;
    endfunction

    task automatic model_step();
        bit oi, oq;
        if (!rst) begin
            collecting = 0; waiting = 0; e_trig = 0; e_busy = 0; m_len = 0; m_got = 0;
            for (int w = 0; w < 2; w++) begin
                m_acc_i[w] = 0; m_acc_q[w] = 0; m_sat[w] = 0;
                e_i[w] = 0; e_q[w] = 0; e_sat[w] = 0;
            end
        end else begin
            e_trig = 0;
            if (waiting) begin
                if (ml_idle) begin
                    for (int w = 0; w < 2; w++) begin
                        e_i[w] = m_acc_i[w]; e_q[w] = m_acc_q[w]; e_sat[w] = m_sat[w];
                    end
                    e_trig  = 1;
                    waiting = 0;
                end
            end else if (collecting) begin
                if (sample_valid) begin
                    for (int w = 0; w < 2; w++) begin
                        m_acc_i[w] = add_clamp(m_acc_i[w], longint'(sample_i), W[w], oi);
                        m_acc_q[w] = add_clamp(m_acc_q[w], longint'(sample_q), W[w], oq);
                        m_sat[w]   = m_sat[w] | oi | oq;
                    end
                    m_got++;
                    if (m_got == m_len) begin collecting = 0; waiting = 1; end
                end
            end else if (arm && window_len != 0) begin
                collecting = 1; m_len = int'(window_len); m_got = 0;
                for (int w = 0; w < 2; w++) begin
                    m_acc_i[w] = 0; m_acc_q[w] = 0; m_sat[w] = 0;
                end
            end
            e_busy = collecting || waiting;
        end
    endtask

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("data32", d32, {32'(e_i[0]), 32'(e_q[0])});
            check("trig32", 64'(t32), 64'(e_trig));
            check("sat32",  64'(s32), 64'(e_sat[0]));
            check("busy32", 64'(b32), 64'(e_busy));
            check("data18", 64'(d18), 64'({18'(e_i[1]), 18'(e_q[1])}));
            check("trig18", 64'(t18), 64'(e_trig));
            check("sat18",  64'(s18), 64'(e_sat[1]));
            check("busy18", 64'(b18), 64'(e_busy));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(bit a, int len, bit v, int si, int sq);
        arm = a; window_len = 10'(len); sample_valid = v;
        sample_i = 16'(si); sample_q = 16'(sq);
        cyc();
    endtask

    task automatic idle_in();
        arm = 0; sample_valid = 0; sample_i = 0; sample_q = 0;
    endtask

    task automatic wait_trig(string name, int budget);
        idle_in();
        for (int k = 0; k < budget; k++) begin
            if (t32) break;
            cyc();
        end
        check(name, 64'(t32), 64'd1);
    endtask

    int pulses;
    int valid_pat [6] = '{1, 0, 0, 1, 0, 1};
    int vi;

    initial begin
        rst = 0; ml_idle = 1; window_len = 0;
        idle_in();
        cyc(); cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_data", d32, 64'd0);
        check("rst_busy", 64'(b32), 64'd0);
        check("rst_trig", 64'(t32), 64'd0);
        rst = 1;
        cyc();

        // Test 1: len=4, I=100, Q=-50.
        drive(1, 4, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 0, 1, 100, -50);
        wait_trig("t1_trig", 10);
        check("t1_data",  d32, 64'h00000190_FFFFFF38);
        check("t1_model", {32'(e_i[0]), 32'(e_q[0])}, 64'h00000190_FFFFFF38);
        check("t1_sat",   64'(s32), 64'd0);
        check("t1_busy",  64'(b32), 64'd0);
        cyc();

        // Test 2: len=3 with gaps.
        drive(1, 3, 0, 0, 0);
        vi = 1;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, valid_pat[k] != 0, vi, 0);
            if (valid_pat[k] != 0) vi++;
            if (k < 5) check("t2_no_early", 64'(t32), 64'd0);
        end
        wait_trig("t2_trig", 10);
        check("t2_data", d32, 64'h00000006_00000000);
        cyc();

        // Test 3: result held while the core is busy.
        ml_idle = 0;
        drive(1, 2, 0, 0, 0);
        drive(0, 0, 1, 7, -3);
        drive(0, 0, 1, 7, -3);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 1, 1000, 1000);
            check("t3_no_trig", 64'(t32), 64'd0);
            check("t3_hold",    d32, 64'h00000006_00000000);
        end
        ml_idle = 1;
        drive(0, 0, 1, 1000, 1000);
        check("t3_trig", 64'(t32), 64'd1);
        check("t3_data", d32, 64'h0000000E_FFFFFFFA);
        idle_in(); cyc();

        // Test 4: 18-bit saturation, then a clean window.
        drive(1, 8, 0, 0, 0);
        for (int k = 0; k < 8; k++) drive(0, 0, 1, 32767, 0);
        wait_trig("t4_trig", 10);
        check("t4_acc18",  64'(d18[35:18]), 64'd131071);
        check("t4_sat18",  64'(s18), 64'd1);
        check("t4_acc32",  64'(d32[63:32]), 64'd262136);
        check("t4_sat32",  64'(s32), 64'd0);
        cyc();
        drive(1, 2, 0, 0, 0);
        drive(0, 0, 1, 1, 1);
        drive(0, 0, 1, 1, 1);
        wait_trig("t4b_trig", 10);
        check("t4b_sat18", 64'(s18), 64'd0);
        cyc();

        // Test 5: reset mid-window.
        drive(1, 4, 0, 0, 0);
        drive(0, 0, 1, 9, 9);
        drive(0, 0, 1, 9, 9);
        rst = 0;
        drive(0, 0, 1, 9, 9);
        check("t5_data", d32, 64'd0);
        check("t5_busy", 64'(b32), 64'd0);
        check("t5_sat",  64'(s18), 64'd0);
        rst = 1;
        drive(0, 0, 0, 0, 0);
        check("t5_no_trig", 64'(t32), 64'd0);
        drive(1, 2, 0, 0, 0);
        drive(0, 0, 1, 5, 0);
        drive(0, 0, 1, 5, 0);
        wait_trig("t5_trig", 10);
        check("t5_acc", d32, 64'h0000000A_00000000);
        cyc();

        // Test 6: zero length ignored; held arm re-issues windows.
        for (int k = 0; k < 3; k++) drive(1, 0, 1, 3, 3);
        check("t6_busy", 64'(b32), 64'd0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            drive(1, 1, 1, 3, 3);
            if (t32) pulses++;
        end
        check("t6_pulses", 64'(pulses), 64'd5);
        idle_in();
        for (int k = 0; k < 4; k++) cyc();

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 299) != 0);
            ml_idle      = ($urandom_range(0, 9) < 7);
            arm          = ($urandom_range(0, 3) == 0);
            window_len   = 10'($urandom_range(0, 6));
            sample_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) begin
                sample_i = 16'($urandom); sample_q = 16'($urandom);
            end else begin
                sample_i = 16'(($urandom_range(0, 200)) - 100);
                sample_q = 16'(($urandom_range(0, 200)) - 100);
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
